// File: rtl/rand_tick_gen_if.sv
// -----------------------------------------------------------------------------
// rand_tick_gen_if
//   Groups the control inputs and registered outputs of rand_tick_gen into one
//   bundle. The clock and reset stay outside as plain ports.
//
//   Signals:
//     pause      : freeze the BCD timer (divider and LFSR keep running)
//     timer_clr  : synchronous clear of the BCD timer
//     seed_load  : one-cycle strobe that loads seed into the LFSR
//     seed       : LFSR seed value (0 is replaced by 1)
//     tick       : one-cycle pulse, high in the cycle new values first appear
//     ascii      : current letter, 8'h41..8'h5A
//     x          : current position, 0..X_MAX
//     time_bcd   : BCD timer, least-significant digit in bits [3:0]
//
//   Modports:
//     master : the side that drives the controls (testbench / game logic)
//     slave  : the generator itself
// -----------------------------------------------------------------------------
interface rand_tick_gen_if #(
  parameter int LFSR_W     = 16,
  parameter int X_W        = 6,
  parameter int BCD_DIGITS = 2
);
  logic                    pause;
  logic                    timer_clr;
  logic                    seed_load;
  logic [LFSR_W-1:0]       seed;
  logic                    tick;
  logic [7:0]              ascii;
  logic [X_W-1:0]          x;
  logic [4*BCD_DIGITS-1:0] time_bcd;

  modport master (
    output pause, timer_clr, seed_load, seed,
    input  tick, ascii, x, time_bcd
  );

  modport slave (
    input  pause, timer_clr, seed_load, seed,
    output tick, ascii, x, time_bcd
  );
endinterface

// File: rtl/rand_tick_gen.sv
// -----------------------------------------------------------------------------
// rand_tick_gen
//   Divides clk_50 down to a periodic tick. On every tick a Galois LFSR steps
//   and a new uppercase letter and bounded X position are registered, and a
//   pausable multi-digit BCD elapsed-time counter advances.
//
//   Ports:
//     clk_50 : system clock, rising edge
//     reset  : synchronous, active-high reset
//     bus    : rand_tick_gen_if.slave (pause, timer_clr, seed_load, seed in;
//              tick, ascii, x, time_bcd out)
//
//   Optional feature (compile-time macro RAND_NO_REPEAT_EN):
//     When defined, a step whose candidate letter equals the current letter
//     emits the following letter instead (Z wraps to A). The LFSR sequence is
//     not affected.
// -----------------------------------------------------------------------------
module rand_tick_gen #(
  parameter int                TICK_DIV   = 50_000_000,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400,
  parameter int                X_W        = 6,
  parameter int                X_MAX      = 63,
  parameter int                BCD_DIGITS = 2
) (
  input logic            clk_50,
  input logic            reset,
  rand_tick_gen_if.slave bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TIM_W = 4 * BCD_DIGITS;

  logic [CNT_W-1:0]  r_div_cnt;
  logic              r_tick;
  logic [LFSR_W-1:0] r_lfsr;
  logic [7:0]        r_ascii;
  logic [X_W-1:0]    r_x;
  logic [TIM_W-1:0]  r_time;

  logic              w_tick_edge;
  logic [LFSR_W-1:0] w_lfsr_shift;
  logic [LFSR_W-1:0] w_lfsr_step;
  logic [LFSR_W-1:0] w_seed_val;
  logic [7:0]        w_ascii_cand;
  logic [7:0]        w_ascii_next;
  logic [X_W-1:0]    w_x_raw;
  logic [X_W-1:0]    w_x_next;
  logic [TIM_W-1:0]  w_time_inc;
  logic              w_carry;

  // Divider terminal count: this edge wraps the counter and raises tick.
  assign w_tick_edge = (r_div_cnt == CNT_W'(TICK_DIV - 1));

  // Galois step; an all-zero result would lock the LFSR, so force it to 1.
  assign w_lfsr_shift = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
  assign w_lfsr_step  = (w_lfsr_shift == '0) ? LFSR_W'(1) : w_lfsr_shift;
  assign w_seed_val   = (bus.seed == '0) ? LFSR_W'(1) : bus.seed;

  assign w_ascii_cand = 8'h41 + (w_lfsr_step[7:0] % 8'd26);

`ifdef RAND_NO_REPEAT_EN
  assign w_ascii_next = (w_ascii_cand != r_ascii) ? w_ascii_cand :
                        (w_ascii_cand == 8'h5A)   ? 8'h41 : w_ascii_cand + 8'd1;
`else
  assign w_ascii_next = w_ascii_cand;
`endif

  // X position from the top X_W LFSR bits. When the range covers the whole
  // field the modulo is the identity, and X_MAX+1 would not fit in X_W bits.
  assign w_x_raw = w_lfsr_step[LFSR_W-1 -: X_W];

  generate
    if (X_MAX + 1 == (1 << X_W)) begin : g_x_full
      assign w_x_next = w_x_raw;
    end else begin : g_x_mod
      assign w_x_next = w_x_raw % X_W'(X_MAX + 1);
    end
  endgenerate

  // BCD increment with ripple carry; all nines rolls over to all zeros.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_time_inc = r_time;
    w_carry    = 1'b1;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (w_carry) begin
        if (r_time[4*d +: 4] == 4'd9) begin
          w_time_inc[4*d +: 4] = 4'd0;
        end else begin
          w_time_inc[4*d +: 4] = r_time[4*d +: 4] + 4'd1;
          w_carry              = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_50) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (reset) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
      r_lfsr    <= LFSR_W'(1);
      r_ascii   <= 8'h41;
      r_x       <= '0;
      r_time    <= '0;
    end else begin
      r_tick    <= w_tick_edge;
      r_div_cnt <= w_tick_edge ? '0 : r_div_cnt + CNT_W'(1);

      // A seed load wins over a step on the same edge; ascii/x then hold.
      if (bus.seed_load) begin
        r_lfsr <= w_seed_val;
      end else if (w_tick_edge) begin
        r_lfsr  <= w_lfsr_step;
        r_ascii <= w_ascii_next;
        r_x     <= w_x_next;
      end

      if (bus.timer_clr) begin
        r_time <= '0;
      end else if (w_tick_edge && !bus.pause) begin
        r_time <= w_time_inc;
      end
    end
  end

  assign bus.tick     = r_tick;
  assign bus.ascii    = r_ascii;
  assign bus.x        = r_x;
  assign bus.time_bcd = r_time;

endmodule

// File: doc/rand_tick_gen.md
# rand_tick_gen

Parametrised pseudo-random letter/position generator with a built-in tick divider and BCD elapsed-time counter for the typing-game datapath. Divides `clk_50` down to a periodic tick. On each tick it advances a Galois LFSR, emits a new uppercase ASCII letter and a bounded X position, and advances a pausable multi-digit BCD timer. It adds configurable width, depth and range, seed loading, timer clear and an optional no-repeat mode.

## Interface
- `TICK_DIV`, 50_000_000: `clk_50` cycles per tick; must be ≥ 2.
- `LFSR_W`, 16: LFSR state width; must be ≥ 8 and ≥ `X_W`.
- `LFSR_TAPS`, 16'hB400: Galois feedback mask, `LFSR_W` bits wide.
- `X_W`, 6: width of the `x` output.
- `X_MAX`, 63: largest legal `x` value; must satisfy X_MAX < 2^X_W.
- `BCD_DIGITS`, 2: number of timer digits.

Ports:
- `clk_50` in 1: system clock; all logic is clocked on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `pause` in 1: while high, the timer holds; the LFSR keeps running.
- `timer_clr` in 1: synchronous clear of the timer.
- `seed_load` in 1: one-cycle strobe; loads `seed` into the LFSR.
- `seed` in `LFSR_W`: seed value.
- `tick` out 1: one-cycle pulse, high in the cycle the new values first appear.
- `ascii` out 8: current letter, in the range 8'h41..8'h5A.
- `x` out `X_W`: current position, in the range 0..X_MAX.
- `time_bcd` out 4*`BCD_DIGITS`: BCD timer with the least-significant digit in bits [3:0].

## Operation
- Reset values:
  - divider count = 0, `tick` = 0
  - LFSR = 1
  - `ascii` = 8'h41, `x` = 0
  - `time_bcd` = 0
- Divider:
  - Counts 0..TICK_DIV-1.
  - At the edge where count == TICK_DIV-1, count wraps to 0 and `tick` is registered high for one cycle.
  - Otherwise `tick` = 0.
- LFSR step on a tick edge:
  - Let b = s[0]. The next state is s' = (s >> 1) ^ (b ? LFSR_TAPS : 0).
  - If s' == 0, load 1 instead (lock-up guard).
- Outputs on the same tick edge, computed from s' (after the guard):
  - `ascii` = 8'h41 + (s'[7:0] mod 26).
  - `x` = s'[LFSR_W-1 -: X_W] mod (X_MAX+1).
  - Both are registered.
- Timer on a tick edge with `pause` = 0:
  - The BCD value increments by 1 with digit-wise carry.
  - All-nines wraps to all-zeros.
- Seed load: on a cycle with `seed_load` = 1, the LFSR is loaded with `seed` (1 if `seed` == 0).
  - `ascii` and `x` hold until the next step.
- Simultaneous events, in priority order:
  - `reset` overrides everything.
  - `seed_load` with a tick edge: the seed is loaded and no step occurs. `ascii`/`x` hold, but `tick` still pulses and the timer still counts.
  - `timer_clr` beats increment: the timer goes to 0 regardless of `pause` or tick.
  - `pause` does not affect the divider, LFSR, `ascii` or `x`.
- Reset asserted mid-period restores all reset values. The next tick then comes TICK_DIV cycles after `reset` deasserts.

## Timing
- Tick period is exactly `TICK_DIV` cycles. The first `tick` is high in cycle TICK_DIV after reset release, counting the first post-reset edge as cycle 1.
- `ascii`, `x` and `time_bcd` change only on the edge that raises `tick`, except for `timer_clr` and `reset`.
- Seed-to-output latency is the next tick edge after the load.
- `timer_clr` takes effect on the next edge (1-cycle latency).
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `RAND_NO_REPEAT_EN` defined:
  - If a step's candidate letter equals the current `ascii`, the output is the next letter instead, with 8'h5A wrapping to 8'h41.
  - The LFSR sequence itself is unchanged.
- Undefined: repeated letters are allowed.

## Test plan
Use TICK_DIV=4 and defaults otherwise.
- Reset release, run 3 ticks:
  - LFSR goes 0xB400, 0x5A00, 0x2D00.
  - `x` goes 45, 22, 11.
  - First `ascii` = 8'h41.
  - Second `ascii` = 8'h41 with the macro undefined, 8'h42 with it defined.
- Run 99 ticks, then 1 more, with `pause`=0: `time_bcd` reads 8'h99, then wraps to 8'h00.
- Hold `pause`=1 for 5 ticks: `time_bcd` is frozen while `x`/`ascii` still change each tick.
- Pulse `seed_load` with `seed`=0 on a tick edge: LFSR = 1, `ascii`/`x` unchanged, `tick` still pulses, timer increments.
- Assert `timer_clr` on a tick edge with `time_bcd`=8'h37: next value is 8'h00, not 8'h01.
- Assert `reset` at divider count 2: all outputs return to reset values, and the next `tick` comes 4 cycles after release.
